// File: rtl/param_step_counter_if.sv
// Handshake-free control/status bundle for param_step_counter.
// master drives controls and reads the count; slave is the counter.
interface param_step_counter_if #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
);
    logic              en;
    logic              up_dn;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              clr_ovf;
    logic [WIDTH-1:0]  result;
    logic              tc;
    logic              ovf;

    modport master (
        output en,
        output up_dn,
        output load,
        output load_val,
        output step,
        output limit,
        output clr_ovf,
        input  result,
        input  tc,
        input  ovf
    );

    modport slave (
        input  en,
        input  up_dn,
        input  load,
        input  load_val,
        input  step,
        input  limit,
        input  clr_ovf,
        output result,
        output tc,
        output ovf
    );
endinterface

// File: rtl/param_step_counter.sv
// Programmable step/modulus up-down counter with prescaler and sticky overflow.
// Define COUNTER_SAT_EN to saturate at the range bounds instead of wrapping.
module param_step_counter #(
    parameter int WIDTH    = 32,
    parameter int STEP_W   = 8,
    parameter int PRESCALE = 1
) (
    input logic                 clk,
    input logic                 reset,
    param_step_counter_if.slave bus
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [WIDTH-1:0] result_q, result_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [PS_W-1:0]  pre_q, pre_d;

    logic [WIDTH:0]   lim_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH:0]   up_sum;
    logic             up_over;
    logic             dn_under;
    logic             step_zero;
    logic             adv_strobe;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] over_val;
    logic [WIDTH-1:0] under_val;
    logic [WIDTH-1:0] adv_val;
    logic             adv_wrap;

    // Widen operands by one bit so limit==0 can stand for the full 2^WIDTH range.
    always_comb begin
        lim_ext   = (bus.limit == '0) ? {1'b1, {WIDTH{1'b0}}}
                                      : {1'b0, bus.limit};
        step_ext  = (WIDTH + 1)'(bus.step);
        res_ext   = {1'b0, result_q};
        up_sum    = res_ext + step_ext;
        up_over   = (up_sum >= lim_ext);
        dn_under  = (res_ext < step_ext);
        step_zero = (step_ext == '0);
        dn_val    = result_q - step_ext[WIDTH-1:0];
    end

    // Out-of-range landing values; modular arithmetic keeps the
    // result inside WIDTH bits even for an oversized step.
    always_comb begin
`ifdef COUNTER_SAT_EN
        over_val  = lim_ext[WIDTH-1:0] - WIDTH'(1);
        under_val = '0;
`else
        over_val  = up_sum[WIDTH-1:0] - lim_ext[WIDTH-1:0];
        under_val = result_q + lim_ext[WIDTH-1:0]
                  - step_ext[WIDTH-1:0];
`endif
    end

    // Value and wrap flag an advance would produce this cycle.
    always_comb begin
        adv_val  = result_q;
        adv_wrap = 1'b0;
        unique case (1'b1)
            step_zero: begin
                adv_val  = result_q;
            end
            (!step_zero && bus.up_dn && up_over): begin
                adv_val  = over_val;
                adv_wrap = 1'b1;
            end
            (!step_zero && bus.up_dn && !up_over): begin
                adv_val  = up_sum[WIDTH-1:0];
            end
            (!step_zero && !bus.up_dn && dn_under): begin
                adv_val  = under_val;
                adv_wrap = 1'b1;
            end
            (!step_zero && !bus.up_dn && !dn_under): begin
                adv_val  = dn_val;
            end
        endcase
    end

    // Prescaler strobe fires on the last enabled cycle of each period.
    always_comb begin
        adv_strobe = bus.en && (pre_q == PS_LAST);
    end

    // Load beats advance beats hold; a wrap sets ovf even under clr_ovf.
    always_comb begin
        result_d = result_q;
        pre_d    = pre_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            result_d = bus.load_val;
            pre_d    = '0;
        end else if (bus.en) begin
            if (adv_strobe) begin
                pre_d    = '0;
                result_d = adv_val;
                tc_d     = adv_wrap;
            end else begin
                pre_d    = pre_q + PS_W'(1);
            end
        end
        ovf_d = tc_d | (ovf_q & ~bus.clr_ovf);
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
            pre_q    <= '0;
        end else begin
            result_q <= result_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
            pre_q    <= pre_d;
        end
    end

    assign bus.result = result_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;

endmodule
